// File: rtl/t_frame_buffer.sv
// -----------------------------------------------------------------------------
// t_frame_buffer
//
// Ping-pong frame store placed after the T(0, i) stage. Incoming frames (a
// contiguous run of t_valid, addresses 0..I-1, three T values per entry) are
// written into whichever of two banks is free; completed frames are replayed
// in address order over a valid/ready stream. The writer never stalls: a frame
// that finds its bank still occupied is dropped whole and flagged.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   t_valid, t_addr         upstream entry strobe and address
//   t_data_0..2             T values for nu = 0, 1, 2
//   out_valid, out_ready    replay handshake
//   out_data_0..2           replayed T values (bit-exact copies)
//   out_index, out_last     address of the replayed entry, final-entry marker
//   frame_done              one-cycle pulse when a bank is committed full
//   overflow, seq_err       sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module t_frame_buffer #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 t_valid,
    input  logic [$clog2(I)-1:0] t_addr,
    input  logic [BIT_WIDTH-1:0] t_data_0,
    input  logic [BIT_WIDTH-1:0] t_data_1,
    input  logic [BIT_WIDTH-1:0] t_data_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data_0,
    output logic [BIT_WIDTH-1:0] out_data_1,
    output logic [BIT_WIDTH-1:0] out_data_2,
    output logic [$clog2(I)-1:0] out_index,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 seq_err
);

    localparam int AW = $clog2(I);
    localparam int LW = AW + 1;
    localparam int DW = 3 * BIT_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic       {R_IDLE, R_STREAM}       r_state_t;

    w_state_t        w_state, w_next;
    r_state_t        r_state, r_next;
    logic [1:0]      full_q, full_next;
    logic [LW-1:0]   len_q [2];
    logic            wr_bank, rd_bank;
    logic [LW-1:0]   exp_q, exp_next;
    logic [LW-1:0]   rd_ptr;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   mem [2][I];

    logic            we, commit, set_ovf, set_seq;
    logic [LW-1:0]   commit_len;
    logic            rd_done, fetch, bank_free;

    // The reader finishing a bank in this cycle frees it for a writer start
    // in the same cycle.
    assign rd_done   = (r_state == R_STREAM) && out_valid && out_ready && out_last;
    assign bank_free = !full_q[wr_bank] || (rd_done && (rd_bank == wr_bank));

    // A new entry is fetched whenever the output slot is empty or being
    // consumed, so a held out_ready gives one entry per cycle.
    assign fetch = (r_state == R_STREAM) && (!out_valid || out_ready)
                && (rd_ptr < len_q[rd_bank]);

    // -------------------------------------------------------------------------
    // Writer next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can infer a latch.
        w_next     = w_state;
        exp_next   = exp_q;
        we         = 1'b0;
        commit     = 1'b0;
        commit_len = exp_q;
        set_ovf    = 1'b0;
        set_seq    = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (t_valid) begin
                    if (t_addr == '0) begin
                        if (bank_free) begin
                            we       = 1'b1;
                            exp_next = LW'(1);
                            w_next   = W_FILL;
                        end else begin
                            set_ovf = 1'b1;
                            w_next  = W_DROP;
                        end
                    end else begin
                        set_seq = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (t_valid) begin
                    exp_next = exp_q + LW'(1);
                    we       = ({1'b0, t_addr} < LW'(I));
                    if ({1'b0, t_addr} != exp_q) begin
                        set_seq = 1'b1;
                    end
                    // Address I-1 closes the frame; the entry count reaching I
                    // also closes it so the length can never exceed a bank.
                    if ((t_addr == AW'(I - 1)) || (exp_q == LW'(I - 1))) begin
                        commit     = 1'b1;
                        commit_len = exp_q + LW'(1);
                        w_next     = W_IDLE;
                    end
                end else begin
                    // A full-length frame always ends on its I-th entry above,
                    // so any frame closed by t_valid falling is short.
                    commit  = 1'b1;
                    set_seq = 1'b1;
                    w_next  = W_IDLE;
                end
            end
            W_DROP: begin
                if (!t_valid) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Reader next-state logic and bank occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:   if (full_q[rd_bank]) r_next = R_STREAM;
            R_STREAM: if (rd_done)         r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    // Writer and reader always own different banks, so a set and a clear in
    // the same cycle never collide.
    always_comb begin
        full_next = full_q;
        if (commit)  full_next[wr_bank] = 1'b1;
        if (rd_done) full_next[rd_bank] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            full_q     <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            exp_q      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            seq_err    <= 1'b0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_last   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            w_state    <= w_next;
            r_state    <= r_next;
            full_q     <= full_next;
            exp_q      <= exp_next;
            frame_done <= commit;
            if (set_ovf) overflow <= 1'b1;
            if (set_seq) seq_err  <= 1'b1;
            if (commit) begin
                len_q[wr_bank] <= commit_len;
                wr_bank        <= ~wr_bank;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end

            if (r_state == R_IDLE) begin
                rd_ptr <= '0;
            end else if (fetch) begin
                rd_ptr <= rd_ptr + LW'(1);
            end

            if (fetch) begin
                out_valid <= 1'b1;
                out_index <= rd_ptr[AW-1:0];
                out_last  <= (rd_ptr == len_q[rd_bank] - LW'(1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame storage: simple dual-port RAM with a registered read port
    // -------------------------------------------------------------------------
    // NOTE: the storage array itself has no reset; bank contents are made
    // meaningless by clearing full_q, which keeps the array mappable to BRAM.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[wr_bank][t_addr] <= {t_data_2, t_data_1, t_data_0};
        end
    end

    // The read register only loads on fetch, so replayed data holds while
    // the consumer stalls.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_data <= '0;
        end else if (fetch) begin
            rd_data <= mem[rd_bank][rd_ptr[AW-1:0]];
        end
    end

    assign out_data_0 = rd_data[BIT_WIDTH-1:0];
    assign out_data_1 = rd_data[2*BIT_WIDTH-1:BIT_WIDTH];
    assign out_data_2 = rd_data[3*BIT_WIDTH-1:2*BIT_WIDTH];

endmodule

// File: tb/tb_t_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_t_frame_buffer
//
// Bench for t_frame_buffer. A frame-level reference model (bank contents,
// occupancy and a queue of committed frames) predicts every replayed entry and
// every flag; directed scenarios come from a table, followed by hand-written
// overflow and reset sequences and a randomized run.
// -----------------------------------------------------------------------------
module tb_t_frame_buffer;

    localparam int BW = 32;
    localparam int I  = 160;
    localparam int AW = $clog2(I);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          t_valid = 1'b0;
    logic [AW-1:0] t_addr = '0;
    logic [BW-1:0] t_data_0 = '0, t_data_1 = '0, t_data_2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data_0, out_data_1, out_data_2;
    logic [AW-1:0] out_index;
    logic          out_last, frame_done, overflow, seq_err;

    always #5 clk_in = ~clk_in;

    t_frame_buffer #(.BIT_WIDTH(BW), .I(I)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .t_valid    (t_valid),
        .t_addr     (t_addr),
        .t_data_0   (t_data_0),
        .t_data_1   (t_data_1),
        .t_data_2   (t_data_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_index  (out_index),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overflow   (overflow),
        .seq_err    (seq_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: what each bank holds, which banks are occupied, and
    // the frames waiting to be replayed, in order.
    // ---------------------------------------------------------------------
    typedef struct { int bank; int len; } frame_t;

    logic [BW-1:0] m_mem0 [2][I];
    logic [BW-1:0] m_mem1 [2][I];
    logic [BW-1:0] m_mem2 [2][I];
    bit            m_vld  [2][I];
    bit            m_full [2];
    frame_t        m_q[$];
    int            m_rd_idx, m_wbank, m_wstate, m_cnt, m_total;
    bit            m_ovf, m_seq, m_fd_pend;

    // per-scenario observations
    int            st_outs, st_fd, st_last_idx, st_last_cnt, fd_cyc, first_lat, cyc;
    logic [BW-1:0] st_idx5;
    logic [BW-1:0] first_d0_q[$];
    bit            prev_valid, stall_pend;
    logic [AW-1:0] sv_index;
    logic          sv_last;
    logic [BW-1:0] sv_d0, sv_d1, sv_d2;

    function automatic void model_reset();
        foreach (m_vld[b, k]) m_vld[b][k] = 1'b0;
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_q.delete();
        m_rd_idx = 0; m_wbank = 0; m_wstate = 0; m_cnt = 0; m_total = 0;
        m_ovf = 1'b0; m_seq = 1'b0; m_fd_pend = 1'b0;
        prev_valid = 1'b0; stall_pend = 1'b0;
    endfunction

    function automatic void model_write();
        m_mem0[m_wbank][t_addr] = t_data_0;
        m_mem1[m_wbank][t_addr] = t_data_1;
        m_mem2[m_wbank][t_addr] = t_data_2;
        m_vld[m_wbank][t_addr]  = 1'b1;
    endfunction

    function automatic void model_commit();
        frame_t f;
        f.bank = m_wbank;
        f.len  = m_cnt;
        m_q.push_back(f);
        m_full[m_wbank] = 1'b1;
        m_total  += m_cnt;
        m_fd_pend = 1'b1;
        m_wbank  ^= 1;
        m_wstate  = 0;
    endfunction

    // Monitor: samples on the falling edge, i.e. the values the DUT will
    // register on the next rising edge.
    initial forever begin
        @(negedge clk_in);
        cyc++;
        if (!rst_in) begin
            model_reset();
            continue;
        end

        check("frame_done", 64'(frame_done), 64'(m_fd_pend));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("seq_err",    64'(seq_err),    64'(m_seq));
        if (frame_done) begin
            st_fd++;
            fd_cyc = cyc;
        end

        if (stall_pend) begin
            check("stall_valid", 64'(out_valid),  64'(1'b1));
            check("stall_index", 64'(out_index),  64'(sv_index));
            check("stall_last",  64'(out_last),   64'(sv_last));
            check("stall_d0",    64'(out_data_0), 64'(sv_d0));
            check("stall_d1",    64'(out_data_1), 64'(sv_d1));
            check("stall_d2",    64'(out_data_2), 64'(sv_d2));
        end
        stall_pend = out_valid && !out_ready;
        sv_index = out_index; sv_last = out_last;
        sv_d0 = out_data_0; sv_d1 = out_data_1; sv_d2 = out_data_2;

        if (out_valid && !prev_valid && first_lat < 0) first_lat = cyc - fd_cyc;
        prev_valid = out_valid;

        // reader side: each handshake consumes the next expected entry
        if (out_valid && m_q.size() == 0) begin
            check("valid_without_frame", 64'(out_valid), 64'(1'b0));
        end else if (out_valid && out_ready) begin
            int b, idx, len;
            b   = m_q[0].bank;
            len = m_q[0].len;
            idx = m_rd_idx;
            check("out_index", 64'(out_index), 64'(idx));
            check("out_last",  64'(out_last),  64'(idx == len - 1));
            if (m_vld[b][idx]) begin
                check("out_data_0", 64'(out_data_0), 64'(m_mem0[b][idx]));
                check("out_data_1", 64'(out_data_1), 64'(m_mem1[b][idx]));
                check("out_data_2", 64'(out_data_2), 64'(m_mem2[b][idx]));
            end
            st_outs++;
            if (out_last) begin
                st_last_cnt++;
                st_last_idx = int'(out_index);
            end
            if (idx == 5) st_idx5 = out_data_0;
            if (idx == 0) first_d0_q.push_back(out_data_0);
            m_rd_idx++;
            if (idx == len - 1) begin
                m_full[b] = 1'b0;
                m_rd_idx  = 0;
                void'(m_q.pop_front());
            end
        end

        // writer side: a bank freed by the handshake above is already free
        m_fd_pend = 1'b0;
        case (m_wstate)
            0: if (t_valid) begin
                   if (t_addr == '0) begin
                       if (!m_full[m_wbank]) begin
                           model_write();
                           m_cnt = 1;
                           m_wstate = 1;
                       end else begin
                           m_ovf = 1'b1;
                           m_wstate = 2;
                       end
                   end else begin
                       m_seq = 1'b1;
                   end
               end
            1: if (t_valid) begin
                   if (int'(t_addr) < I) model_write();
                   if (int'(t_addr) != m_cnt) m_seq = 1'b1;
                   m_cnt++;
                   if (int'(t_addr) == I - 1 || m_cnt == I) model_commit();
               end else begin
                   m_seq = 1'b1;
                   model_commit();
               end
            default: if (!t_valid) m_wstate = 0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    int ready_mode = 0;   // 0 always, 1 pattern 1-0-0-1, 2 random, 3 held low
    int rcnt = 0;
    int fa[$];

    initial forever begin
        @(posedge clk_in);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        rcnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic void build_frame(input int len, input bit ooo);
        fa.delete();
        if (ooo) begin
            fa.push_back(0); fa.push_back(1); fa.push_back(2);
            for (int a = 5; a < I; a++) fa.push_back(a);
        end else begin
            for (int a = 0; a < len; a++) fa.push_back(a);
        end
    endfunction

    task automatic send_frame(input logic [BW-1:0] salt, input bit rnd);
        foreach (fa[k]) begin
            t_valid  = 1'b1;
            t_addr   = AW'(fa[k]);
            t_data_0 = rnd ? $urandom() : salt + BW'(fa[k]);
            t_data_1 = rnd ? $urandom() : salt + BW'(fa[k]) + 32'd1000;
            t_data_2 = rnd ? $urandom() : salt + BW'(fa[k]) + 32'd2000;
            @(posedge clk_in);
            #1;
        end
        t_valid = 1'b0;
    endtask

    task automatic clear_stats();
        st_outs = 0; st_fd = 0; st_last_idx = -1; st_last_cnt = 0;
        fd_cyc = 0; first_lat = -1; st_idx5 = '0;
        first_d0_q.delete();
    endtask

    task automatic do_reset();
        t_valid = 1'b0;
        rst_in  = 1'b0;
        idle(2);
        check("rst_out_valid",  64'(out_valid),  64'(1'b0));
        check("rst_out_last",   64'(out_last),   64'(1'b0));
        check("rst_frame_done", 64'(frame_done), 64'(1'b0));
        check("rst_overflow",   64'(overflow),   64'(1'b0));
        check("rst_seq_err",    64'(seq_err),    64'(1'b0));
        check("rst_out_index",  64'(out_index),  64'(0));
        check("rst_out_data",   {out_data_1, out_data_0}, 64'(0));
        check("rst_out_data_2", 64'(out_data_2), 64'(0));
        rst_in = 1'b1;
        clear_stats();
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 3000;
        while ((m_q.size() != 0 || m_wstate != 0 || out_valid) && budget > 0) begin
            idle(1);
            budget--;
        end
        check({name, "_drain_timeout"}, 64'(budget > 0), 64'(1'b1));
        idle(4);
        check({name, "_idle_valid"}, 64'(out_valid), 64'(1'b0));
    endtask

    // ---------------------------------------------------------------------
    // Directed scenario table
    // ---------------------------------------------------------------------
    typedef struct {
        int len;        // frame length when addresses are in order
        bit ooo;        // address sequence 0,1,2,5..I-1
        int rmode;      // out_ready pattern
        int exp_outs;   // entries replayed
        int exp_last;   // out_index carrying out_last
        bit exp_seq;    // seq_err after the frame
    } scen_t;

    scen_t tbl[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{len: 160, ooo: 1'b0, rmode: 0, exp_outs: 160, exp_last: 159, exp_seq: 1'b0};
        tbl[1] = '{len: 100, ooo: 1'b0, rmode: 0, exp_outs: 100, exp_last:  99, exp_seq: 1'b1};
        tbl[2] = '{len: 160, ooo: 1'b1, rmode: 0, exp_outs: 158, exp_last: 157, exp_seq: 1'b1};
        tbl[3] = '{len: 160, ooo: 1'b0, rmode: 1, exp_outs: 160, exp_last: 159, exp_seq: 1'b0};
        tbl[4] = '{len:   1, ooo: 1'b0, rmode: 2, exp_outs:   1, exp_last:   0, exp_seq: 1'b1};

        for (int s = 0; s < 5; s++) begin
            logic [BW-1:0] salt;
            salt = BW'(s) << 16;
            do_reset();
            ready_mode = tbl[s].rmode;
            build_frame(tbl[s].len, tbl[s].ooo);
            send_frame(salt, 1'b0);
            idle(1);
            wait_drain($sformatf("scen%0d", s));
            check($sformatf("scen%0d_outputs", s),  64'(st_outs),     64'(tbl[s].exp_outs));
            check($sformatf("scen%0d_last_idx", s), 64'(st_last_idx), 64'(tbl[s].exp_last));
            check($sformatf("scen%0d_last_cnt", s), 64'(st_last_cnt), 64'(1));
            check($sformatf("scen%0d_frame_done", s), 64'(st_fd),     64'(1));
            check($sformatf("scen%0d_seq_err", s),  64'(seq_err),     64'(tbl[s].exp_seq));
            check($sformatf("scen%0d_overflow", s), 64'(overflow),    64'(1'b0));
            if (s == 0) check("frame_done_to_valid", 64'(first_lat), 64'(2));
            if (tbl[s].ooo) check("ooo_index5_data", 64'(st_idx5), 64'(salt + 32'd5));
        end

        // Overflow: three back-to-back frames with the consumer stalled.
        do_reset();
        ready_mode = 3;
        build_frame(I, 1'b0);
        send_frame(32'h0001_0000, 1'b0); idle(1);
        send_frame(32'h0002_0000, 1'b0); idle(1);
        send_frame(32'h0003_0000, 1'b0); idle(5);
        check("ovf_flag",       64'(overflow), 64'(1'b1));
        check("ovf_frame_done", 64'(st_fd),    64'(2));
        ready_mode = 0;
        wait_drain("ovf");
        check("ovf_outputs",     64'(st_outs),           64'(2 * I));
        check("ovf_frame_count", 64'(first_d0_q.size()), 64'(2));
        if (first_d0_q.size() == 2) begin
            check("ovf_first_frame",  64'(first_d0_q[0]), 64'(32'h0001_0000));
            check("ovf_second_frame", 64'(first_d0_q[1]), 64'(32'h0002_0000));
        end

        // Reset in the middle of a replay, then a clean frame.
        begin
            int budget;
            do_reset();
            ready_mode = 0;
            build_frame(I, 1'b0);
            send_frame(32'h0004_0000, 1'b0);
            budget = 1000;
            while (!(out_valid && out_index == AW'(40)) && budget > 0) begin
                idle(1);
                budget--;
            end
            check("mid_reset_reach_idx40", 64'(budget > 0), 64'(1'b1));
            #2;
            rst_in = 1'b0;
            #1;
            check("mid_reset_valid", 64'(out_valid),  64'(1'b0));
            check("mid_reset_last",  64'(out_last),   64'(1'b0));
            check("mid_reset_index", 64'(out_index),  64'(0));
            check("mid_reset_data",  {out_data_1, out_data_0}, 64'(0));
            check("mid_reset_data2", 64'(out_data_2), 64'(0));
            idle(2);
            rst_in = 1'b1;
            clear_stats();
            send_frame(32'h0005_0000, 1'b0);
            idle(1);
            wait_drain("post_reset");
            check("post_reset_outputs", 64'(st_outs),  64'(I));
            check("post_reset_fd",      64'(st_fd),    64'(1));
            check("post_reset_seq",     64'(seq_err),  64'(1'b0));
            check("post_reset_ovf",     64'(overflow), 64'(1'b0));
        end

        // Randomized traffic: mixed lengths, stray entries, random gaps and
        // a random consumer; drops and flags come from the model.
        do_reset();
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int len, gap;
            if ($urandom_range(0, 7) == 0) begin
                t_valid = 1'b1;
                t_addr  = AW'($urandom_range(1, I - 1));
                idle(1);
                t_valid = 1'b0;
                idle(1);
            end
            len = ($urandom_range(0, 9) < 5) ? I : int'($urandom_range(1, I));
            build_frame(len, 1'b0);
            send_frame('0, 1'b1);
            gap = (len == I) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            idle(gap);
        end
        idle(1);
        wait_drain("random");
        check("random_outputs", 64'(st_outs), 64'(m_total));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/t_frame_buffer.md
# t_frame_buffer

Double-buffered frame store that sits directly downstream of the T(0, i) stage. It captures the three sequential T-value streams (one entry per address, I addresses per frame) into a ping-pong bank and replays each completed frame to the next stage over a valid/ready stream. The writer always accepts at full rate. Frames arriving while both banks are occupied are dropped and flagged, never partially overwritten.

## Interface
- BIT_WIDTH, 32, width of each T value
- I, 160, entries per frame (addresses 0..I-1)
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-low
- t_valid  in  1  upstream entry valid; a frame is a contiguous run of t_valid high
- t_addr  in  $clog2(I)  upstream entry address
- t_data_0 / t_data_1 / t_data_2  in  BIT_WIDTH each  T values for nu = 0, 1, 2
- out_valid  out  1  replay entry valid
- out_ready  in  1  downstream accepts the entry this cycle
- out_data_0 / out_data_1 / out_data_2  out  BIT_WIDTH each  replayed T values
- out_index  out  $clog2(I)  address of the replayed entry
- out_last  out  1  high with the final entry of the frame
- frame_done  out  1  one-cycle pulse when a bank becomes full
- overflow  out  1  sticky; a frame was dropped
- seq_err  out  1  sticky; an address was out of order or a frame was malformed

## Operation
- Storage: 2 banks × I entries × 3·BIT_WIDTH, inferred as BRAM with 1-cycle read latency. Per-bank state is full[b] and len[b] ($clog2(I)+1 bits). Pointers are wr_bank and rd_bank.
- Writer FSM states: W_IDLE, W_FILL, W_DROP.
  - W_IDLE, t_valid & t_addr==0: if !full[wr_bank], write entry 0, set exp=1, go to W_FILL. Otherwise set overflow and go to W_DROP.
  - W_IDLE, t_valid & t_addr!=0: entry ignored, seq_err set, stay in W_IDLE.
  - W_FILL, t_valid: write at t_addr and increment exp. If t_addr!=exp, set seq_err; the write still goes to t_addr.
  - W_FILL, frame ends (t_valid low, or the entry at address I-1 is written): set full[wr_bank], set len[wr_bank]=exp (after increment when ending on I-1), pulse frame_done, toggle wr_bank, go to W_IDLE.
  - A frame with len < I (t_valid falls early) is still committed, and seq_err is set.
  - If a frame ends on address I-1 while t_valid stays high the next cycle, that next entry is handled as in W_IDLE.
  - W_DROP: discard entries until t_valid is low, then go to W_IDLE.
- Reader FSM states: R_IDLE, R_STREAM.
  - R_IDLE: when full[rd_bank], start prefetching address 0 and go to R_STREAM.
  - R_STREAM: present entries 0..len-1 in order. Each out_valid & out_ready handshake advances by one entry. out_last is high on entry len-1.
  - After the last handshake, clear full[rd_bank], toggle rd_bank, go to R_IDLE.
- Simultaneous events: the writer setting full on one bank and the reader clearing full on the other in the same cycle both take effect. A frame start in the same cycle that the reader frees wr_bank sees the bank as free.
- Data is stored and replayed bit-exact; the block performs no arithmetic on it.
- overflow and seq_err clear only on reset.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid, out_last, frame_done, overflow, seq_err = 0. out_data_*, out_index = 0. Both banks empty; wr_bank = rd_bank = 0; FSMs in W_IDLE / R_IDLE.
- frame_done is registered; it asserts the cycle after the last entry (or after t_valid falls).
- First out_valid asserts 2 cycles after frame_done, provided the reader is idle on that bank.
- Sustained replay is 1 entry/cycle while out_ready is held high; there are no bubbles inside a frame.
- Backpressure: while out_valid & !out_ready, out_data_*, out_index and out_last hold stable.
- Back-to-back frames: the next frame may start the cycle after t_valid falls. If that frame's bank is still unread, the frame is dropped.
- Reset mid-frame or mid-replay discards all bank contents immediately.

## Test plan
- Single frame: t_addr 0..159 with t_data_0 = addr, t_data_1 = addr+1000, t_data_2 = addr+2000, out_ready high -> frame_done pulses once; 160 outputs arrive in order with matching data; out_last only at index 159; no flags set.
- Backpressure: same frame, out_ready toggled 1-0-0-1 repeatedly -> every entry is delivered exactly once; outputs hold stable while stalled.
- Overflow: three back-to-back frames, out_ready low -> frames 1 and 2 are stored, frame 3 is dropped and overflow=1. Raising out_ready then replays frame 1 followed by frame 2.
- Short frame: t_valid high for addresses 0..99 only -> seq_err=1; len=100; 100 outputs with out_last at index 99.
- Out-of-order address: sequence 0,1,2,5,... -> seq_err=1; entry 5 is replayed at out_index 5.
- Reset: rst_in pulsed low mid-replay at index 40 -> all outputs 0 immediately. A following frame replays cleanly starting from bank 0.
